// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with hold > bubble > load priority.
// Optional bubble counter output when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imme_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [9:0]      funct_i,
  input  logic            reg_write_i,
  input  logic            mem_to_reg_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            alu_src_i,
  input  logic [1:0]      alu_op_i,
  input  logic            hold_i,
  input  logic            bubble_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imme_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [9:0]      funct_o,
  output logic            reg_write_o,
  output logic            mem_to_reg_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            alu_src_o,
  output logic [1:0]      alu_op_o
`ifdef ID_EX_BUBBLE_CNT_EN
  ,output logic [31:0]    bubble_cnt_o
`endif
);
  logic ld, ctl;
  // data fields survive an invalid load; control and rd only pass for a real instruction
  assign ld  = ~bubble_i;
  assign ctl = ~bubble_i & valid_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      pc_o         <= '0;
      rs1_data_o   <= '0;
      rs2_data_o   <= '0;
      imme_o       <= '0;
      rs1_addr_o   <= '0;
      rs2_addr_o   <= '0;
      rd_addr_o    <= '0;
      funct_o      <= '0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      alu_src_o    <= 1'b0;
      alu_op_o     <= '0;
    end else if (!hold_i) begin
      valid_o      <= ctl;
      pc_o         <= ld ? pc_i : '0;
      rs1_data_o   <= ld ? rs1_data_i : '0;
      rs2_data_o   <= ld ? rs2_data_i : '0;
      imme_o       <= ld ? imme_i : '0;
      rs1_addr_o   <= ld ? rs1_addr_i : '0;
      rs2_addr_o   <= ld ? rs2_addr_i : '0;
      rd_addr_o    <= ctl ? rd_addr_i : '0;
      funct_o      <= ld ? funct_i : '0;
      reg_write_o  <= ctl & reg_write_i;
      mem_to_reg_o <= ctl & mem_to_reg_i;
      mem_read_o   <= ctl & mem_read_i;
      mem_write_o  <= ctl & mem_write_i;
      alu_src_o    <= ctl & alu_src_i;
      alu_op_o     <= ld ? alu_op_i : '0;
    end
  end
`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bubble_cnt_o <= '0;
    else if (!hold_i && bubble_i && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized bench for id_ex_reg against a per-edge action model.
module tb_id_ex_reg;
  localparam int XLEN = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic valid_i = 1'b0, hold_i = 1'b0, bubble_i = 1'b0;
  logic [XLEN-1:0] pc_i = '0, rs1_data_i = '0, rs2_data_i = '0, imme_i = '0;
  logic [4:0] rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
  logic [9:0] funct_i = '0;
  logic reg_write_i = 1'b0, mem_to_reg_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0, alu_src_i = 1'b0;
  logic [1:0] alu_op_i = '0;
  logic valid_o;
  logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imme_o;
  logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [9:0] funct_o;
  logic reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o;
  logic [1:0] alu_op_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_o;
`endif
  logic [160:0] outs, exp_s, snap;
  logic [31:0] exp_cnt;
  int checks = 0, errors = 0;

  id_ex_reg #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imme_i(imme_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .funct_i(funct_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .alu_src_i(alu_src_i), .alu_op_i(alu_op_i),
    .hold_i(hold_i), .bubble_i(bubble_i), .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imme_o(imme_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rd_addr_o(rd_addr_o), .funct_o(funct_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,.bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  assign outs = {valid_o, pc_o, rs1_data_o, rs2_data_o, imme_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
                 funct_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, alu_op_o};

  task automatic chk(input string tag, input logic [160:0] got, input logic [160:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // what the register should hold after one edge, given its present contents
  function automatic logic [160:0] nxt(input logic [160:0] cur);
    if (hold_i) return cur;
    if (bubble_i) return '0;
    return {valid_i, pc_i, rs1_data_i, rs2_data_i, imme_i, rs1_addr_i, rs2_addr_i,
            valid_i ? rd_addr_i : 5'd0, funct_i,
            valid_i ? {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i} : 5'd0,
            alu_op_i};
  endfunction

  task automatic rnd_in();
    valid_i = 1'($urandom); pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom;
    imme_i = $urandom; rs1_addr_i = 5'($urandom); rs2_addr_i = 5'($urandom); rd_addr_i = 5'($urandom);
    funct_i = 10'($urandom); {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i} = 5'($urandom);
    alu_op_i = 2'($urandom);
  endtask

  task automatic step(input string tag);
    logic [160:0] n;
    logic [31:0] c;
    n = nxt(exp_s);
    c = (!hold_i && bubble_i && exp_cnt != 32'hFFFF_FFFF) ? exp_cnt + 32'd1 : exp_cnt;
    @(posedge clk);
    #1;
    exp_s = n;
    exp_cnt = c;
    chk(tag, outs, exp_s);
    chk({tag, "_inv"}, valid_o ? 3'b0 : {reg_write_o, mem_read_o, mem_write_o}, 3'b0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk({tag, "_cnt"}, bubble_cnt_o, exp_cnt);
`endif
  endtask

  initial begin
    exp_s = '0;
    exp_cnt = '0;
    rnd_in();
    #12;
    chk("reset_state", outs, '0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("reset_cnt", bubble_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    // basic load
    rnd_in();
    valid_i = 1'b1; pc_i = 32'h0000_0010; imme_i = 32'hFFFF_FFFC; reg_write_i = 1'b1;
    step("load");
    chk("load_pc", pc_o, 32'h10);
    chk("load_imm", imme_o, 32'hFFFF_FFFC);
    chk("load_rw", {valid_o, reg_write_o}, 2'b11);
    // hold wins over bubble and tracks nothing on the inputs
    snap = outs;
    hold_i = 1'b1; bubble_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      step("hold");
      chk("hold_snap", outs, snap);
    end
    // bubble
    hold_i = 1'b0; rnd_in(); mem_write_i = 1'b1; rd_addr_i = 5'd5; valid_i = 1'b1;
    step("bubble");
    chk("bubble_fields", {valid_o, mem_write_o, rd_addr_o}, 7'd0);
    // invalid load keeps data, drops control and rd
    bubble_i = 1'b0; rnd_in(); valid_i = 1'b0; reg_write_i = 1'b1; rd_addr_i = 5'd7; rs1_data_i = 32'hA5A5_A5A5;
    step("invalid");
    chk("invalid_fields", {reg_write_o, rd_addr_o, rs1_data_o}, {1'b0, 5'd0, 32'hA5A5_A5A5});
    // asynchronous reset pulse between edges
    rnd_in(); valid_i = 1'b1;
    step("pre_rst");
    #1 rst = 1'b1;
    #2;
    chk("async_rst", outs, '0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("async_rst_cnt", bubble_cnt_o, 32'd0);
`endif
    rst = 1'b0;
    exp_s = '0;
    exp_cnt = '0;
    rnd_in(); valid_i = 1'b1;
    step("post_rst");
`ifdef ID_EX_BUBBLE_CNT_EN
    // saturation: preset near the top then bubble past it
    @(negedge clk);
    force dut.bubble_cnt_o = 32'hFFFF_FFFE;
    #1 release dut.bubble_cnt_o;
    exp_cnt = 32'hFFFF_FFFE;
    bubble_i = 1'b1;
    step("sat1");
    step("sat2");
    chk("sat_value", bubble_cnt_o, 32'hFFFF_FFFF);
    bubble_i = 1'b0;
`endif
    for (int i = 0; i < 2000; i++) begin
      rnd_in();
      hold_i = ($urandom_range(0, 4) == 0);
      bubble_i = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc, register-data and immediate fields.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 valid_i  input  1  decode stage holds a real instruction this cycle.
REQ-005 pc_i, rs1_data_i, rs2_data_i, imme_i  input  XLEN each  decoded PC, register-file read data, sign-extended immediate.
REQ-006 rs1_addr_i, rs2_addr_i, rd_addr_i  input  5 each  source/destination register indices.
REQ-007 funct_i  input  10  {funct7, funct3} for ALU control.
REQ-008 reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i  input  1 each  decode control bits; alu_op_i  input  2  ALU op class.
REQ-009 hold_i  input  1  freeze register contents (downstream/memory stall).
REQ-010 bubble_i  input  1  load a NOP instead of decode data (load-use hazard or branch flush).
REQ-011 Outputs valid_o plus one *_o per REQ-005..REQ-008 input, same widths, registered.
REQ-012 bubble_cnt_o  output  32  bubbles inserted (present only per REQ-024).

Function
REQ-013 Each rising edge, exactly one action, priority hold_i > bubble_i > load.
REQ-014 Hold: every output retains its current value, regardless of bubble_i and valid_i.
REQ-015 Bubble (hold_i=0, bubble_i=1): valid_o, all control outputs, alu_op_o, rd_addr_o, rs1_addr_o, rs2_addr_o, funct_o and all XLEN fields become 0.
REQ-016 Load (hold_i=0, bubble_i=0): every output takes its input value; valid_o <= valid_i.
REQ-017 Load with valid_i=0: control outputs and rd_addr_o forced to 0, data fields still captured; no architectural side effect downstream.
REQ-018 Latency exactly one cycle from input to output; no combinational input-to-output path.
REQ-019 Whenever valid_o=0, reg_write_o, mem_read_o, mem_write_o shall be 0 (invariant).
REQ-020 Immediate and data fields pass bit-exact; no extension or truncation inside the block.

Reset
REQ-021 rst_i=1 immediately (asynchronously) drives every output, including bubble_cnt_o, to 0.
REQ-022 Reset asserted mid-hold or mid-bubble overrides both; first edge after release performs a normal REQ-013 action.
REQ-023 rst_i released coincident with a clock edge: that edge is not required to load; the following edge shall.

Configuration
REQ-024 Macro ID_EX_BUBBLE_CNT_EN defined: bubble_cnt_o exists, increments by 1 on every edge taking the bubble action (REQ-015), unchanged on hold and load, saturates at 32'hFFFF_FFFF.
REQ-025 Macro ID_EX_BUBBLE_CNT_EN undefined: bubble_cnt_o port and counter logic absent; all other behaviour identical.

Verification
REQ-026 Reset then load valid_i=1, pc_i=32'h0000_0010, imme_i=32'hFFFF_FFFC, reg_write_i=1 -> next cycle pc_o=32'h10, imme_o=32'hFFFF_FFFC, reg_write_o=1, valid_o=1.
REQ-027 Loaded state, then hold_i=1 and bubble_i=1 for 3 cycles with changing inputs -> outputs unchanged all 3 cycles; bubble_cnt_o unchanged.
REQ-028 bubble_i=1, hold_i=0 with mem_write_i=1, rd_addr_i=5 -> next cycle valid_o=0, mem_write_o=0, rd_addr_o=0; bubble_cnt_o increments by 1.
REQ-029 valid_i=0, reg_write_i=1, rd_addr_i=7, rs1_data_i=32'hA5A5_A5A5 -> reg_write_o=0, rd_addr_o=0, rs1_data_o=32'hA5A5_A5A5.
REQ-030 rst_i pulsed between clock edges while valid_o=1 -> all outputs 0 before next edge; next load after release captures inputs normally.
REQ-031 With ID_EX_BUBBLE_CNT_EN, counter preset via 2^32-1 bubbles (or forced) then one more bubble -> bubble_cnt_o stays 32'hFFFF_FFFF.
